alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised successor to the 2-bit alu_op/funct ALU decoder. It combines the decode with a registered
//  execute stage and a valid/ready handshake on input and output. Adds NOR/SLL/SRL, an iterative unsigned
//  multiply (MULTU) into HI/LO, MFHI/MFLO reads, and an illegal-op flag.
//  Sits between ID/EX operand latch and EX/MEM; stalls upstream via in_ready while a multiply iterates.
// PARAMETERS
//  DATA_W     32  operand/result width (>=8, power of 2)
//  SHAMT_W    $clog2(DATA_W)  shift-amount width (derived, not overridden)
//  MUL_EN     1   0: MULTU/MFHI/MFLO decode as illegal, no multiplier built
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        synchronous, active-high reset
//  in_valid   in   1        operation present
//  in_ready   out  1        unit accepts operation this cycle
//  alu_op     in   2        00 add, 01 sub, 10 R-type (use funct), 11 illegal
//  funct      in   6        R-type function field
//  shamt      in   SHAMT_W  shift amount for SLL/SRL
//  op_a       in   DATA_W   rs operand
//  op_b       in   DATA_W   rt operand
//  out_valid  out  1        result register holds a result
//  out_ready  in   1        downstream consumes result
//  result     out  DATA_W   operation result
//  zero       out  1        result == 0
//  illegal    out  1        operation was undecodable (result forced 0)
// BEHAVIOUR
//  Clock/reset: one clock; reset is synchronous and active-high (clk, rst).
//  Reset: out_valid=0, result=0, zero=1, illegal=0, HI=LO=0, FSM=IDLE; in_ready=0 during reset cycle.
//  Decode (select, 4b): alu_op 00->ADD 0010, 01->SUB 0110; 10 by funct: 100000 ADD, 100010 SUB,
//   100100 AND 0000, 100101 OR 0001, 100111 NOR 1100, 101010 SLT 0111 (signed), 000000 SLL 1000,
//   000010 SRL 1001, 011001 MULTU 1010, 010000 MFHI 1011, 010010 MFLO 1101; anything else -> illegal.
//  Arithmetic: ADD/SUB modulo 2^DATA_W, no overflow trap; SLT result is {DATA_W-1 zeros, a<b signed}.
//  Handshake: transfer on in_valid&&in_ready; in_ready = (state==IDLE) && (!out_valid || out_ready).
//   Output holds result/zero/illegal stable while out_valid&&!out_ready; drops when consumed
//   unless a new result loads the same cycle.
//  FSM: IDLE -> (accept non-MULTU) load result reg, out_valid=1 next cycle (latency 1), stay IDLE.
//   IDLE -> (accept MULTU) MUL: shift-add, one bit of op_b per cycle, DATA_W cycles; then DONE.
//   DONE: write {HI,LO}=a*b (2*DATA_W), result=LO, out_valid=1, -> IDLE. MULTU latency DATA_W+1.
//  MFHI/MFLO accepted only in IDLE, so they always see the completed product (no hazard).
//  Back-to-back single-cycle ops with out_ready=1: one result per cycle.
//  Illegal op: accepted normally, result=0, zero=1, illegal=1, HI/LO unchanged, latency 1.
//  rst mid-multiply: abandon, FSM=IDLE, HI/LO=0, no result emitted.
//  in_valid while in MUL/DONE: ignored (in_ready=0); caller must hold it.
// STRUCTURE
//  Shared package alu_pkg: select localparams (SEL_AND..SEL_MFLO), funct localparams, alu_op codes,
//   FSM state encoding (IDLE/MUL/DONE).
//  Sub-module alu_mul_iter (start, a, b -> busy, done, product[2*DATA_W-1:0]); generated only if MUL_EN.
//  Top holds decode, single-cycle datapath, HI/LO, FSM, output register.
// TESTING
//  alu_op=10 funct=100000 a=7 b=5, out_ready=1 -> next cycle out_valid, result=12, zero=0.
//  funct=101010 a=32'hFFFF_FFFF b=1 -> result=1 (signed); funct=100010 a=5 b=5 -> result=0, zero=1.
//  funct=011001 a=32'h0001_0000 b=32'h0001_0000 -> in_ready=0 for 33 cycles, then LO=0, HI=1;
//   follow with MFHI -> result=1.
//  out_ready=0 for 3 cycles after ADD result -> result held, in_ready=0, no second result lost.
//  alu_op=11 or funct=111111 -> illegal=1, result=0; MUL_EN=0 with MULTU -> illegal=1.
//  rst asserted 10 cycles into MULTU -> out_valid stays 0, HI=LO=0, in_ready=1 next cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared decode constants, FSM states and helpers for the ALU execute unit.
// Imported by alu_exec_unit and alu_mul_iter.
package alu_pkg;

   localparam logic [1:0] OP_ADD   = 2'b00;
   localparam logic [1:0] OP_SUB   = 2'b01;
   localparam logic [1:0] OP_RTYPE = 2'b10;
   localparam logic [1:0] OP_ILL   = 2'b11;

   localparam logic [5:0] FN_ADD   = 6'b100000;
   localparam logic [5:0] FN_SUB   = 6'b100010;
   localparam logic [5:0] FN_AND   = 6'b100100;
   localparam logic [5:0] FN_OR    = 6'b100101;
   localparam logic [5:0] FN_NOR   = 6'b100111;
   localparam logic [5:0] FN_SLT   = 6'b101010;
   localparam logic [5:0] FN_SLL   = 6'b000000;
   localparam logic [5:0] FN_SRL   = 6'b000010;
   localparam logic [5:0] FN_MULTU = 6'b011001;
   localparam logic [5:0] FN_MFHI  = 6'b010000;
   localparam logic [5:0] FN_MFLO  = 6'b010010;

   localparam logic [3:0] SEL_AND   = 4'b0000;
   localparam logic [3:0] SEL_OR    = 4'b0001;
   localparam logic [3:0] SEL_ADD   = 4'b0010;
   localparam logic [3:0] SEL_SUB   = 4'b0110;
   localparam logic [3:0] SEL_SLT   = 4'b0111;
   localparam logic [3:0] SEL_SLL   = 4'b1000;
   localparam logic [3:0] SEL_SRL   = 4'b1001;
   localparam logic [3:0] SEL_MULTU = 4'b1010;
   localparam logic [3:0] SEL_MFHI  = 4'b1011;
   localparam logic [3:0] SEL_NOR   = 4'b1100;
   localparam logic [3:0] SEL_MFLO  = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      MUL  = 2'b01,
      DONE = 2'b10
   } state_t;

   typedef struct packed {
      logic [3:0] sel;
      logic       ill;
   } dec_t;

   function automatic dec_t decode(
      input logic [1:0] op,
      input logic [5:0] fn,
      input bit         mul_en
   );
      dec_t d;
      d.sel = SEL_AND;
      d.ill = 1'b0;
      unique case (op)
         OP_ADD: d.sel = SEL_ADD;
         OP_SUB: d.sel = SEL_SUB;
         OP_RTYPE: begin
            unique case (fn)
               FN_ADD: d.sel = SEL_ADD;
               FN_SUB: d.sel = SEL_SUB;
               FN_AND: d.sel = SEL_AND;
               FN_OR:  d.sel = SEL_OR;
               FN_NOR: d.sel = SEL_NOR;
               FN_SLT: d.sel = SEL_SLT;
               FN_SLL: d.sel = SEL_SLL;
               FN_SRL: d.sel = SEL_SRL;
               FN_MULTU: begin
                  d.sel = SEL_MULTU;
                  d.ill = !mul_en;
               end
               FN_MFHI: begin
                  d.sel = SEL_MFHI;
                  d.ill = !mul_en;
               end
               FN_MFLO: begin
                  d.sel = SEL_MFLO;
                  d.ill = !mul_en;
               end
               default: d.ill = 1'b1;
            endcase
         end
         default: d.ill = 1'b1;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per cycle.
// done is high during the final iteration so the caller can leave MUL then.
module alu_mul_iter
   import alu_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DATA_W-1:0]     a,
   input  logic [DATA_W-1:0]     b,
   output logic                  busy,
   output logic                  done,
   output logic [2*DATA_W-1:0]   product
);

   localparam int CNT_W = $clog2(DATA_W);

   logic [2*DATA_W-1:0] mcand;
   logic [2*DATA_W-1:0] acc;
   logic [DATA_W-1:0]   mplier;
   logic [CNT_W-1:0]    cnt;

   assign done    = busy && (cnt == CNT_W'(DATA_W - 1));
   assign product = acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy   <= 1'b0;
         cnt    <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         mcand  <= {{DATA_W{1'b0}}, a};
         mplier <= b;
         acc    <= '0;
         cnt    <= '0;
         busy   <= 1'b1;
      end else if (busy) begin
         if (mplier[0]) acc <= acc + mcand;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         cnt    <= cnt + 1'b1;
         if (done) busy <= 1'b0;
      end
   end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage: decode, single-cycle datapath, HI/LO,
// iterative MULTU and a valid/ready result register.
module alu_exec_unit
   import alu_pkg::*;
#(
   parameter int   DATA_W  = 32,
   localparam int  SHAMT_W = $clog2(DATA_W),
   parameter bit   MUL_EN  = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         alu_op,
   input  logic [5:0]         funct,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic [DATA_W-1:0]  op_a,
   input  logic [DATA_W-1:0]  op_b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [DATA_W-1:0]  result,
   output logic               zero,
   output logic               illegal
);

   state_t              state;
   state_t              state_nxt;
   dec_t                dec;
   logic [DATA_W-1:0]   hi;
   logic [DATA_W-1:0]   lo;
   logic [DATA_W-1:0]   alu_res;
   logic                fire;
   logic                is_mul;
   logic                mul_start;
   logic                mul_busy;
   logic                mul_done;
   logic [2*DATA_W-1:0] mul_prod;

   assign dec       = decode(alu_op, funct, MUL_EN);
   assign in_ready  = !rst && (state == IDLE) && !mul_busy
                      && (!out_valid || out_ready);
   assign fire      = in_valid && in_ready;
   assign is_mul    = (dec.sel == SEL_MULTU) && !dec.ill;
   assign mul_start = fire && is_mul;

   always_comb begin
      alu_res = '0;
      if (!dec.ill) begin
         unique case (dec.sel)
            SEL_ADD:  alu_res = op_a + op_b;
            SEL_SUB:  alu_res = op_a - op_b;
            SEL_AND:  alu_res = op_a & op_b;
            SEL_OR:   alu_res = op_a | op_b;
            SEL_NOR:  alu_res = ~(op_a | op_b);
            SEL_SLT:  alu_res = {{(DATA_W-1){1'b0}},
                                 $signed(op_a) < $signed(op_b)};
            SEL_SLL:  alu_res = op_b << shamt;
            SEL_SRL:  alu_res = op_b >> shamt;
            SEL_MFHI: alu_res = hi;
            SEL_MFLO: alu_res = lo;
            default:  alu_res = '0;
         endcase
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (mul_start) state_nxt = MUL;
         MUL:     if (mul_done) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         hi        <= '0;
         lo        <= '0;
         out_valid <= 1'b0;
         result    <= '0;
         zero      <= 1'b1;
         illegal   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (out_valid && out_ready) out_valid <= 1'b0;
         // A MULTU was accepted with the output empty, so DONE never collides
         if (state == DONE) begin
            {hi, lo}  <= mul_prod;
            result    <= mul_prod[DATA_W-1:0];
            zero      <= (mul_prod[DATA_W-1:0] == '0);
            illegal   <= 1'b0;
            out_valid <= 1'b1;
         end else if (fire && !is_mul) begin
            result    <= alu_res;
            zero      <= (alu_res == '0);
            illegal   <= dec.ill;
            out_valid <= 1'b1;
         end
      end
   end

   if (MUL_EN) begin : g_mul
      alu_mul_iter #(
         .DATA_W (DATA_W)
      ) u_mul (
         .clk     (clk),
         .rst     (rst),
         .start   (mul_start),
         .a       (op_a),
         .b       (op_b),
         .busy    (mul_busy),
         .done    (mul_done),
         .product (mul_prod)
      );
   end else begin : g_nomul
      assign mul_busy = 1'b0;
      assign mul_done = 1'b0;
      assign mul_prod = '0;
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed checks of alu_exec_unit against a behavioural model.
// A second instance with MUL_EN=0 covers the multiplier-less decode.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [1:0]   alu_op = 2'b00;
   logic [5:0]   funct = 6'd0;
   logic [4:0]   shamt = 5'd0;
   logic [W-1:0] op_a = '0;
   logic [W-1:0] op_b = '0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] result;
   logic         zero;
   logic         illegal;

   logic         n_in_valid = 1'b0;
   logic         n_in_ready;
   logic [1:0]   n_alu_op = 2'b10;
   logic [5:0]   n_funct = 6'd0;
   logic [2:0]   n_shamt = 3'd0;
   logic [7:0]   n_op_a = 8'd3;
   logic [7:0]   n_op_b = 8'd5;
   logic         n_out_valid;
   logic [7:0]   n_result;
   logic         n_zero;
   logic         n_illegal;

   int           errs = 0;
   int           checks = 0;
   logic [W-1:0] m_hi = '0;
   logic [W-1:0] m_lo = '0;

   always #5 clk = ~clk;

   alu_exec_unit #(.DATA_W(W), .MUL_EN(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .alu_op(alu_op), .funct(funct), .shamt(shamt),
      .op_a(op_a), .op_b(op_b), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero),
      .illegal(illegal)
   );

   alu_exec_unit #(.DATA_W(8), .MUL_EN(1'b0)) dut_nomul (
      .clk(clk), .rst(rst), .in_valid(n_in_valid), .in_ready(n_in_ready),
      .alu_op(n_alu_op), .funct(n_funct), .shamt(n_shamt),
      .op_a(n_op_a), .op_b(n_op_b), .out_valid(n_out_valid),
      .out_ready(1'b1), .result(n_result), .zero(n_zero),
      .illegal(n_illegal)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: ISA-level meaning of each op; stall = cycles in_ready low
   task automatic model(input logic [1:0] op, input logic [5:0] fn,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh, output logic [W-1:0] r,
                        output logic ill, output int stall);
      logic [63:0] p;
      r = '0;
      ill = 1'b0;
      stall = 0;
      if (op == 2'b00) r = a + b;
      else if (op == 2'b01) r = a - b;
      else if (op == 2'b11) ill = 1'b1;
      else begin
         case (fn)
            6'h20: r = a + b;
            6'h22: r = a - b;
            6'h24: r = a & b;
            6'h25: r = a | b;
            6'h27: r = ~(a | b);
            6'h2A: r = {31'd0, $signed(a) < $signed(b)};
            6'h00: r = b << sh;
            6'h02: r = b >> sh;
            6'h19: begin
               p = 64'(a) * 64'(b);
               m_hi = p[63:32];
               m_lo = p[31:0];
               r = m_lo;
               stall = W + 1;
            end
            6'h10: r = m_hi;
            6'h12: r = m_lo;
            default: ill = 1'b1;
         endcase
      end
   endtask

   task automatic run_op(input string tag, input logic [1:0] op,
                         input logic [5:0] fn, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [4:0] sh);
      logic [W-1:0] er;
      logic         eil;
      int           est;
      int           n;
      int           st;
      model(op, fn, a, b, sh, er, eil, est);
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      alu_op = op;
      funct = fn;
      op_a = a;
      op_b = b;
      shamt = sh;
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check({tag, "/accept_timeout"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1 in_valid = 1'b0;
      n = 0;
      st = 0;
      do begin
         @(negedge clk);
         n++;
         if (!in_ready) st++;
      end while (!out_valid && n < 100);
      check({tag, "/valid"}, 64'(out_valid), 64'd1);
      check({tag, "/result"}, 64'(result), 64'(er));
      check({tag, "/zero"}, 64'(zero), 64'(er == '0));
      check({tag, "/illegal"}, 64'(illegal), 64'(eil));
      check({tag, "/stall"}, 64'(st), 64'(est));
   endtask

   logic [5:0] fn_list [13] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A,
                               6'h00, 6'h02, 6'h19, 6'h10, 6'h12,
                               6'h3F, 6'h01};

   initial begin
      int seen;
      logic [1:0] rop;
      // reset state
      @(negedge clk);
      check("rst/in_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("rst/out_valid", 64'(out_valid), 64'd0);
      check("rst/result", 64'(result), 64'd0);
      check("rst/zero", 64'(zero), 64'd1);
      check("rst/illegal", 64'(illegal), 64'd0);
      rst = 1'b0;
      #1 check("rst/in_ready_after", 64'(in_ready), 64'd1);

      // directed vectors
      run_op("add7_5", 2'b10, 6'h20, 32'd7, 32'd5, 5'd0);
      run_op("slt_neg", 2'b10, 6'h2A, 32'hFFFF_FFFF, 32'd1, 5'd0);
      run_op("sub_eq", 2'b10, 6'h22, 32'd5, 32'd5, 5'd0);
      run_op("multu", 2'b10, 6'h19, 32'h0001_0000, 32'h0001_0000, 5'd0);
      run_op("mfhi", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0);
      run_op("mflo", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0);
      run_op("op11", 2'b11, 6'h20, 32'd9, 32'd9, 5'd0);
      run_op("fn3f", 2'b10, 6'h3F, 32'd9, 32'd9, 5'd0);
      run_op("mfhi_kept", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0);
      run_op("sll31", 2'b10, 6'h00, 32'd0, 32'd3, 5'd31);
      run_op("srl31", 2'b10, 6'h02, 32'd0, 32'h8000_0000, 5'd31);

      // back-to-back single-cycle ops
      @(negedge clk);
      in_valid = 1'b1;
      alu_op = 2'b00;
      op_a = 32'd1;
      op_b = 32'd2;
      @(negedge clk);
      check("b2b/rdy", 64'(in_ready), 64'd1);
      check("b2b/r0", 64'(result), 64'd3);
      op_a = 32'd10;
      op_b = 32'd20;
      @(negedge clk);
      check("b2b/v1", 64'(out_valid), 64'd1);
      check("b2b/r1", 64'(result), 64'd30);
      in_valid = 1'b0;
      @(negedge clk);
      check("b2b/drain", 64'(out_valid), 64'd0);

      // output stall keeps the result and blocks input
      out_ready = 1'b0;
      in_valid = 1'b1;
      alu_op = 2'b00;
      op_a = 32'd100;
      op_b = 32'd23;
      @(negedge clk);
      op_a = 32'd1;
      op_b = 32'd1;
      for (int i = 0; i < 3; i++) begin
         check("stall/valid", 64'(out_valid), 64'd1);
         check("stall/held", 64'(result), 64'd123);
         check("stall/in_ready", 64'(in_ready), 64'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1 check("stall/release", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check("stall/second", 64'(result), 64'd2);
      check("stall/second_v", 64'(out_valid), 64'd1);
      @(negedge clk);

      // reset in the middle of a multiply
      in_valid = 1'b1;
      alu_op = 2'b10;
      funct = 6'h19;
      op_a = 32'd3;
      op_b = 32'd5;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (9) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_hi = '0;
      m_lo = '0;
      #1;
      check("mrst/in_ready", 64'(in_ready), 64'd1);
      check("mrst/out_valid", 64'(out_valid), 64'd0);
      seen = 0;
      repeat (40) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mrst/no_emit", 64'(seen), 64'd0);
      run_op("mrst/mfhi", 2'b10, 6'h10, 32'd0, 32'd0, 5'd0);
      run_op("mrst/mflo", 2'b10, 6'h12, 32'd0, 32'd0, 5'd0);

      // randomized ops
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 9))
            0: rop = 2'b00;
            1: rop = 2'b01;
            2: rop = 2'b11;
            default: rop = 2'b10;
         endcase
         run_op("rand", rop, fn_list[$urandom_range(0, 12)],
                $urandom(), ($urandom_range(0, 3) == 0) ? $urandom() : W'($urandom_range(0, 9)),
                5'($urandom_range(0, 31)));
      end

      // build without a multiplier
      @(negedge clk);
      check("nomul/rdy", 64'(n_in_ready), 64'd1);
      n_in_valid = 1'b1;
      n_funct = 6'h19;
      @(negedge clk);
      check("nomul/multu_ill", 64'(n_illegal), 64'd1);
      check("nomul/multu_res", 64'(n_result), 64'd0);
      check("nomul/multu_zero", 64'(n_zero), 64'd1);
      check("nomul/multu_v", 64'(n_out_valid), 64'd1);
      n_funct = 6'h10;
      @(negedge clk);
      check("nomul/mfhi_ill", 64'(n_illegal), 64'd1);
      n_funct = 6'h20;
      @(negedge clk);
      n_in_valid = 1'b0;
      check("nomul/add_ill", 64'(n_illegal), 64'd0);
      check("nomul/add_res", 64'(n_result), 64'd8);

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
